// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver and its future word-source counterpart.
package serial_word_receiver_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rxState_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

    function automatic int cntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_receiver_rx_bit_counter.sv
// Loadable bit counter; terminal flags the edge that samples the last bit of a word.
module rx_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic clear,
    input  logic inc,
    input  logic bitValid,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    // Load starts a word at one bit; completion clears back to zero.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = bitValid && (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with valid/ready output and overrun/resync flags.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SerialIn,
    input  logic             BitValid,
    input  logic             Start,
    input  logic             WordReady,
    input  logic             ClearOvr,
    output logic [WIDTH-1:0] Word,
    output logic             WordValid,
    output logic             Overrun,
    output logic             FrameErr
);

    localparam int CntW = cntWidth(WIDTH);

    rxState_t         state;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] newWord;
    logic [WIDTH-1:0] firstBit;
    logic             terminal;
    logic             inShift;
    logic             complete;

    assign inShift  = (state == ST_SHIFT);
    assign newWord  = {shiftReg[WIDTH-2:0], SerialIn};
    assign firstBit = {{(WIDTH-1){1'b0}}, SerialIn};
    // A Start bit always restarts framing, so it can never complete a word.
    assign complete = inShift && BitValid && !Start && terminal;

    rx_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CntW)
    ) u_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (BitValid && Start),
        .clear    (complete),
        .inc      (inShift && BitValid && !Start),
        .bitValid (BitValid),
        .terminal (terminal)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= ST_IDLE;
            shiftReg  <= '0;
            Word      <= '0;
            WordValid <= 1'b0;
            Overrun   <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            FrameErr <= 1'b0;
            if (ClearOvr) begin
                Overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (BitValid && Start) begin
                        shiftReg <= firstBit;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (BitValid) begin
                        if (Start) begin
                            shiftReg <= firstBit;
                            FrameErr <= 1'b1;
                        end else begin
                            shiftReg <= newWord;
                            if (terminal) begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Overrun set is written after the clear so that it wins on a shared edge.
            if (complete) begin
                if (!WordValid || WordReady) begin
                    Word      <= newWord;
                    WordValid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (WordValid && WordReady) begin
                WordValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver at WIDTH=4.
module tb_serial_word_receiver;

    logic       CLK;
    logic       RST;
    logic       SerialIn;
    logic       BitValid;
    logic       Start;
    logic       WordReady;
    logic       ClearOvr;
    logic [3:0] Word;
    logic       WordValid;
    logic       Overrun;
    logic       FrameErr;

    int checks = 0;
    int errors = 0;

    serial_word_receiver #(.WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SerialIn  (SerialIn),
        .BitValid  (BitValid),
        .Start     (Start),
        .WordReady (WordReady),
        .ClearOvr  (ClearOvr),
        .Word      (Word),
        .WordValid (WordValid),
        .Overrun   (Overrun),
        .FrameErr  (FrameErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic sendBit(input logic b, input logic st);
        SerialIn = b;
        Start    = st;
        BitValid = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycle(input logic junkStart);
        SerialIn = 1'b1;
        Start    = junkStart;
        BitValid = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (Word !== 4'b0000) begin errors++; $display("[TB] FAIL reset_word actual=%b expected=0000", Word); end
        checks++; if (WordValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", WordValid); end
        checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr actual=%b expected=0", Overrun); end
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr actual=%b expected=0", FrameErr); end
        RST = 1'b1;
        WordReady = 1'b0;
        sendBit(1, 1); sendBit(0, 0); sendBit(1, 0); sendBit(0, 0);
        sendBit(0, 1); sendBit(1, 0); sendBit(0, 0); sendBit(1, 0);
        checks++; if (Word !== 4'b1010 || WordValid !== 1'b1 || Overrun !== 1'b1) begin
            errors++; $display("[TB] FAIL pre_reset_state actual=%b/%b/%b expected=1010/1/1", Word, WordValid, Overrun);
        end
        sendBit(1, 1); sendBit(1, 0);
        #2 RST = 1'b0;
        #1;
        checks++; if (Word !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_word actual=%b expected=0000", Word); end
        checks++; if (WordValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid actual=%b expected=0", WordValid); end
        checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ovr actual=%b expected=0", Overrun); end
        #2 RST = 1'b1;
        WordReady = 1'b1;
        sendBit(0, 1);
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("[TB] FAIL postreset_ferr actual=%b expected=0", FrameErr); end
        sendBit(1, 0); sendBit(1, 0);
        checks++; if (WordValid !== 1'b0) begin errors++; $display("[TB] FAIL postreset_early actual=%b expected=0", WordValid); end
        sendBit(1, 0);
        checks++; if (Word !== 4'b0111 || WordValid !== 1'b1) begin
            errors++; $display("[TB] FAIL postreset_word actual=%b/%b expected=0111/1", Word, WordValid);
        end
        idleCycle(0);
    endtask

    task automatic test_single;
        WordReady = 1'b1;
        sendBit(1, 1); sendBit(0, 0); sendBit(1, 0);
        checks++; if (WordValid !== 1'b0) begin errors++; $display("[TB] FAIL single_early actual=%b expected=0", WordValid); end
        sendBit(1, 0);
        checks++; if (Word !== 4'b1011) begin errors++; $display("[TB] FAIL single_word actual=%b expected=1011", Word); end
        checks++; if (WordValid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid actual=%b expected=1", WordValid); end
        checks++; if (Overrun !== 1'b0) begin errors++; $display("[TB] FAIL single_ovr actual=%b expected=0", Overrun); end
        idleCycle(0);
        checks++; if (WordValid !== 1'b0 || Word !== 4'b1011) begin
            errors++; $display("[TB] FAIL single_consumed actual=%b/%b expected=1011/0", Word, WordValid);
        end
    endtask

    task automatic test_gapped;
        WordReady = 1'b1;
        sendBit(0, 1); idleCycle(1);
        sendBit(1, 0); idleCycle(1);
        sendBit(1, 0); idleCycle(0);
        checks++; if (WordValid !== 1'b0 || Word !== 4'b1011 || FrameErr !== 1'b0) begin
            errors++; $display("[TB] FAIL gapped_hold actual=%b/%b/%b expected=1011/0/0", Word, WordValid, FrameErr);
        end
        sendBit(0, 0);
        checks++; if (Word !== 4'b0110 || WordValid !== 1'b1) begin
            errors++; $display("[TB] FAIL gapped_word actual=%b/%b expected=0110/1", Word, WordValid);
        end
        idleCycle(0);
    endtask

    task automatic test_back_to_back;
        WordReady = 1'b1;
        sendBit(1, 1); sendBit(0, 0); sendBit(0, 0); sendBit(1, 0);
        checks++; if (Word !== 4'b1001 || WordValid !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_first actual=%b/%b expected=1001/1", Word, WordValid);
        end
        WordReady = 1'b0;
        sendBit(0, 1); sendBit(1, 0); sendBit(1, 0);
        checks++; if (WordValid !== 1'b1 || Word !== 4'b1001) begin
            errors++; $display("[TB] FAIL b2b_held actual=%b/%b expected=1001/1", Word, WordValid);
        end
        WordReady = 1'b1;
        sendBit(0, 0);
        checks++; if (Word !== 4'b0110 || WordValid !== 1'b1 || Overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_second actual=%b/%b/%b expected=0110/1/0", Word, WordValid, Overrun);
        end
        idleCycle(0);
    endtask

    task automatic test_overrun;
        WordReady = 1'b0;
        sendBit(1, 1); sendBit(1, 0); sendBit(0, 0); sendBit(0, 0);
        checks++; if (Word !== 4'b1100 || WordValid !== 1'b1 || Overrun !== 1'b0) begin
            errors++; $display("[TB] FAIL ovr_first actual=%b/%b/%b expected=1100/1/0", Word, WordValid, Overrun);
        end
        sendBit(0, 1); sendBit(0, 0); sendBit(1, 0); sendBit(1, 0);
        checks++; if (Word !== 4'b1100 || Overrun !== 1'b1) begin
            errors++; $display("[TB] FAIL ovr_drop actual=%b/%b expected=1100/1", Word, Overrun);
        end
        ClearOvr = 1'b1;
        idleCycle(0);
        ClearOvr = 1'b0;
        checks++; if (Overrun !== 1'b0 || WordValid !== 1'b1) begin
            errors++; $display("[TB] FAIL ovr_clear actual=%b/%b expected=0/1", Overrun, WordValid);
        end
        sendBit(1, 1); sendBit(1, 0); sendBit(1, 0);
        ClearOvr = 1'b1;
        sendBit(1, 0);
        ClearOvr = 1'b0;
        checks++; if (Overrun !== 1'b1 || Word !== 4'b1100) begin
            errors++; $display("[TB] FAIL ovr_setwins actual=%b/%b expected=1/1100", Overrun, Word);
        end
        ClearOvr = 1'b1;
        idleCycle(0);
        ClearOvr = 1'b0;
        WordReady = 1'b1;
        idleCycle(0);
        checks++; if (WordValid !== 1'b0 || Overrun !== 1'b0 || Word !== 4'b1100) begin
            errors++; $display("[TB] FAIL ovr_drain actual=%b/%b/%b expected=1100/0/0", Word, WordValid, Overrun);
        end
    endtask

    task automatic test_resync;
        WordReady = 1'b1;
        sendBit(1, 1); sendBit(1, 0);
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("[TB] FAIL resync_quiet actual=%b expected=0", FrameErr); end
        sendBit(0, 1);
        checks++; if (FrameErr !== 1'b1 || WordValid !== 1'b0) begin
            errors++; $display("[TB] FAIL resync_pulse actual=%b/%b expected=1/0", FrameErr, WordValid);
        end
        sendBit(1, 0);
        checks++; if (FrameErr !== 1'b0) begin errors++; $display("[TB] FAIL resync_oneshot actual=%b expected=0", FrameErr); end
        sendBit(0, 0);
        checks++; if (WordValid !== 1'b0) begin errors++; $display("[TB] FAIL resync_early actual=%b expected=0", WordValid); end
        sendBit(1, 0);
        checks++; if (Word !== 4'b0101 || WordValid !== 1'b1 || FrameErr !== 1'b0) begin
            errors++; $display("[TB] FAIL resync_word actual=%b/%b/%b expected=0101/1/0", Word, WordValid, FrameErr);
        end
        idleCycle(0);
    endtask

    initial begin
        RST       = 1'b0;
        SerialIn  = 1'b0;
        BitValid  = 1'b0;
        Start     = 1'b0;
        WordReady = 1'b0;
        ClearOvr  = 1'b0;
        test_reset();
        test_single();
        test_gapped();
        test_back_to_back();
        test_overrun();
        test_resync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-in, parallel-out receiver for the serial side of the parallel-load shift register. It is the receiving end of the same MSB-first serial stream. It assembles WIDTH-bit words from a qualified serial bit stream and presents each completed word on a registered output with a valid/ready handshake. It detects resynchronisation and overrun, so the word source and consumer can be checked independently.

## Interface
- WIDTH, 4: bits per word; legal range 2..16.
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- SerialIn  input  1  serial data bit, sampled only when BitValid=1.
- BitValid  input  1  qualifies SerialIn on this edge.
- Start  input  1  marks the sampled bit as the first (MSB) bit of a word; ignored when BitValid=0.
- WordReady  input  1  consumer accepts Word on this edge.
- ClearOvr  input  1  clears Overrun.
- Word  output  WIDTH  last completed word, MSB = first received bit.
- WordValid  output  1  Word holds an unconsumed word.
- Overrun  output  1  sticky: a word was dropped.
- FrameErr  output  1  one-cycle pulse: a word was restarted before completion.

## Operation
- Reset (RST=0, asynchronous) values:
  - state=IDLE, shift register=0, bit count=0.
  - Word=0, WordValid=0, Overrun=0, FrameErr=0.
- FSM with two states, IDLE and SHIFT.
- IDLE:
  - BitValid&Start: shift register = {.., SerialIn}, count=1, go to SHIFT.
  - BitValid without Start: ignored.
- SHIFT, on each BitValid edge:
  - Shift register = {sr[WIDTH-2:0], SerialIn}, count+1.
  - When the count reaches WIDTH on this edge, the word completes and the FSM returns to IDLE.
- SHIFT with BitValid&Start (resync):
  - Discard the partial word and pulse FrameErr for 1 cycle.
  - Take this bit as the new MSB, count=1, stay in SHIFT.
- Start only applies with BitValid. Cycles with BitValid=0 hold all receive state.
- Word completion when WordValid=0, or WordValid=1&WordReady=1 on the same edge:
  - Word ← {sr[WIDTH-2:0], SerialIn}.
  - WordValid=1 after that edge.
  - Back-to-back words keep WordValid high with no gap.
- Word completion when WordValid=1&WordReady=0:
  - The new word is discarded and Word is unchanged.
  - Overrun ← 1.
- Handshake: a word is transferred on an edge with WordValid&WordReady. With no simultaneous completion, WordValid=0 after that edge. Word is held until overwritten.
- Overrun clears on an edge with ClearOvr=1, unless an overrun occurs on that same edge (set wins).
- A reset mid-word drops the partial word and any pending Word.

## Timing
- Latency: Word/WordValid update on the same edge that samples the WIDTH-th bit, which is WIDTH sampled bits after Start.
- Minimum word period: WIDTH cycles (BitValid held high, Start on every WIDTH-th bit).
- FrameErr is registered and high for exactly the cycle after the resync edge.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package: state encoding localparams ST_IDLE=0, ST_SHIFT=1, and the counter width CNT_W=$clog2(WIDTH+1). These are reused by the future word source.
- One sub-module, rx_bit_counter: loadable up-counter with a terminal flag (count==WIDTH-1 while BitValid).
- The top level contains the FSM, shift register, output register, and flag logic.

## Test plan
All scenarios use WIDTH=4.
- Reset: assert RST=0 mid-word → all outputs 0 immediately; after release, the next Start frames cleanly.
- Single word: bits 1,0,1,1 with Start on the first, WordReady=1 → Word=4'b1011, WordValid high one cycle, Overrun=0.
- Back-to-back: words 1001 then 0110 with continuous BitValid and WordReady=1 → WordValid stays high, Word=1001 then 0110 on consecutive completion edges.
- Gapped bits: BitValid toggled 1,0,1,0,... over bits 0,1,1,0 → Word=4'b0110. Cycles with BitValid=0 change nothing.
- Overrun: WordReady=0, send 1100 then 0011 → Word stays 1100, Overrun=1. ClearOvr pulse → Overrun=0. WordReady=1 → WordValid drops.
- Resync: Start, bits 1,1, then Start with bits 0,1,0,1 → FrameErr pulses once, Word=4'b0101.
